// File: rtl/pwm_capture_if.sv
// pwm_capture_if: groups the PWM input and the capture result signals of pwm_capture.
// The slave modport is the capture block; the master modport is whatever drives/reads it.
interface pwm_capture_if #(
    parameter int CW = 16
);
    logic          pwm_in;
    logic          cap_valid;
    logic [CW-1:0] cap_period;
    logic [CW-1:0] cap_high;
    logic          timeout;
    logic          stuck_level;

    modport master (
        output pwm_in,
        input  cap_valid, cap_period, cap_high, timeout, stuck_level
    );

    modport slave (
        input  pwm_in,
        output cap_valid, cap_period, cap_high, timeout, stuck_level
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rising-to-rising period of an asynchronous PWM input.
// Define PWM_CAPTURE_FILTER_EN to insert a FILT_LEN-cycle glitch filter after the synchroniser.
module pwm_capture #(
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_lvl;
    logic                   w_lvl_next;
    logic                   r_s;
    logic                   r_s_d;
    logic                   w_rise;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [CW-1:0]          r_period_cnt;
    logic [CW-1:0]          w_period_nx;
    logic [CW-1:0]          r_high_cnt;
    logic [CW-1:0]          w_high_nx;
    logic                   r_cap_valid;
    logic                   w_valid_nx;
    logic [CW-1:0]          r_cap_period;
    logic [CW-1:0]          w_cap_period_nx;
    logic [CW-1:0]          r_cap_high;
    logic [CW-1:0]          w_cap_high_nx;
    logic                   r_timeout;
    logic                   w_timeout_nx;
    logic                   r_stuck;
    logic                   w_stuck_nx;

    // Synchroniser chain for the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
        end
    end

    assign w_sync_lvl = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int            FW        = $clog2(FILT_LEN);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

    logic [FW-1:0] r_filt_cnt;
    logic          r_filt;

    // Glitch filter: follow the synchronised level only after FILT_LEN identical cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_cnt <= '0;
            r_filt     <= 1'b0;
        end else if (w_sync_lvl == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt_cnt <= '0;
            r_filt     <= w_sync_lvl;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end

    assign w_lvl_next = r_filt;
`else
    assign w_lvl_next = w_sync_lvl;
`endif

    // Level register and its one-cycle delay for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s   <= 1'b0;
            r_s_d <= 1'b0;
        end else begin
            r_s   <= w_lvl_next;
            r_s_d <= r_s;
        end
    end

    assign w_rise = r_s & ~r_s_d;

    // Measurement state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WAIT_EDGE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_period <= '0;
            r_cap_high   <= '0;
            r_timeout    <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_period_cnt <= w_period_nx;
            r_high_cnt   <= w_high_nx;
            r_cap_valid  <= w_valid_nx;
            r_cap_period <= w_cap_period_nx;
            r_cap_high   <= w_cap_high_nx;
            r_timeout    <= w_timeout_nx;
            r_stuck      <= w_stuck_nx;
        end
    end

    // Next-state logic; a rise in the saturating cycle still produces a normal capture
    always_comb begin
        w_state_nx      = r_state;
        w_period_nx     = r_period_cnt;
        w_high_nx       = r_high_cnt;
        w_valid_nx      = 1'b0;
        w_cap_period_nx = r_cap_period;
        w_cap_high_nx   = r_cap_high;
        w_timeout_nx    = r_timeout;
        w_stuck_nx      = r_stuck;
        case (r_state)
            WAIT_EDGE: begin
                if (w_rise) begin
                    w_period_nx = CNT_ONE;
                    w_high_nx   = CNT_ONE;
                    w_state_nx  = MEASURE;
                end else begin
                    w_state_nx  = WAIT_EDGE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_cap_period_nx = r_period_cnt;
                    w_cap_high_nx   = r_high_cnt;
                    w_valid_nx      = 1'b1;
                    w_period_nx     = CNT_ONE;
                    w_high_nx       = CNT_ONE;
                    w_timeout_nx    = 1'b0;
                end else if (r_period_cnt == CNT_MAX) begin
                    w_timeout_nx = 1'b1;
                    w_stuck_nx   = r_s;
                    w_period_nx  = '0;
                    w_high_nx    = '0;
                    w_state_nx   = WAIT_EDGE;
                end else begin
                    w_period_nx = r_period_cnt + CNT_ONE;
                    if (r_s) begin
                        w_high_nx = r_high_cnt + CNT_ONE;
                    end else begin
                        w_high_nx = r_high_cnt;
                    end
                end
            end
            default: begin
                w_state_nx  = WAIT_EDGE;
                w_period_nx = '0;
                w_high_nx   = '0;
            end
        endcase
    end

    assign bus.cap_valid   = r_cap_valid;
    assign bus.cap_period  = r_cap_period;
    assign bus.cap_high    = r_cap_high;
    assign bus.timeout     = r_timeout;
    assign bus.stuck_level = r_stuck;
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM signal: high time and period, in clk cycles.
- Decode counterpart of the LED gamma PWM generator. Used for loop-back checking of generated PWM and for reading external PWM sensors/fan tach-style inputs on the iCE40-feather.
- Publishes one result per rising-to-rising input period.
- Reports a timeout when the input is stuck (0%/100% duty or disconnected).

Parameters:
- CW, 16, width of period/high counters and result outputs; saturation limit is 2^CW-1.
- SYNC_STAGES, 2, number of input synchroniser flops (minimum 2).
- FILT_LEN, 3, stable-cycle count required by the glitch filter (used only with PWM_CAPTURE_FILTER_EN, minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- cap_valid  out  1  one-cycle strobe: new cap_period/cap_high available.
- cap_period  out  CW  cycles between last two rising edges.
- cap_high  out  CW  cycles input was high within that period.
- timeout  out  1  level: no rising edge within 2^CW-1 cycles.
- stuck_level  out  1  synchronised input level at the moment timeout asserted.

Behaviour:
- Reset: all outputs 0; synchroniser flops 0; counters 0; state WAIT_EDGE. Reset mid-measurement discards the partial period; no cap_valid follows reset until two fresh rising edges.
- Input path: pwm_in → SYNC_STAGES flops → level s (filtered level when macro enabled). Define s_d = s delayed one cycle. rise = s & ~s_d.
- State WAIT_EDGE:
  - On rise: period_cnt←1; high_cnt←1; go to MEASURE; no capture.
  - Otherwise hold. timeout is unchanged.
- State MEASURE, per cycle without rise:
  - period_cnt += 1.
  - high_cnt += 1 if s=1.
- State MEASURE, on rise:
  - cap_period←period_cnt; cap_high←high_cnt; cap_valid←1 for exactly one cycle.
  - period_cnt←1; high_cnt←1; timeout←0; stay in MEASURE.
- Count semantics: for an input with period P and high time H (cycles), a capture yields cap_period=P and cap_high=H.
- Latency: cap_valid is high SYNC_STAGES+1 cycles after the clk edge that first samples pwm_in=1.
- Outputs cap_period and cap_high hold their value until the next capture; they are not cleared by timeout.
- Saturation/timeout:
  - If period_cnt = 2^CW-1 and no rise occurs this cycle: timeout←1; stuck_level←s; go to WAIT_EDGE; no cap_valid.
  - Counters never wrap.
- Simultaneous rise and saturation: rise wins, a normal capture with cap_period=2^CW-1 is produced, and timeout is not set.
- timeout stays high through WAIT_EDGE and the first rise. It clears only on the next completed capture.
- high_cnt can never exceed period_cnt, so no separate overflow check is needed.
- Falling edges carry no special action; duty is implied by cap_high.

Optional Feature:
PWM_CAPTURE_FILTER_EN
- Defined: a glitch filter sits between the synchroniser and s.
  - s changes to the synchronised value only after that value has been stable for FILT_LEN consecutive cycles.
  - The filter resets to 0.
  - Pulses shorter than FILT_LEN cycles are ignored entirely.
  - Latency to cap_valid becomes SYNC_STAGES+FILT_LEN+1 cycles.
  - P and H are still measured exactly, since both edges are delayed equally.
- Not defined: s is the last synchroniser stage directly, and FILT_LEN is unused.

Test Plan:
- Reset, then 4 periods of P=10, H=3 → first rising edge produces no capture. Each later edge gives cap_valid one cycle with cap_period=10, cap_high=3, 3 strobes total, timeout=0.
- P=7, H=6, then P=7, H=1 → captures (7,6), then (7,1) for the first period spanning the change, then (7,1); cap_valid never wider than 1 cycle.
- CW=8, pwm_in held 0 after one valid period → timeout=1 and stuck_level=0 exactly 255 cycles after the last rise; no cap_valid; last capture values retained. Repeat held high → stuck_level=1.
- After timeout, resume P=10, H=5 → timeout stays 1 through the first rise and clears with the first cap_valid (10,5).
- Assert rst for 1 cycle mid-period during steady P=12, H=4 → outputs 0 next cycle. The next edge gives no capture; the following edge gives (12,4).
- With PWM_CAPTURE_FILTER_EN, FILT_LEN=3: P=20, H=8 plus 2-cycle high glitches in the low phase → captures remain (20,8). A 3-cycle glitch gives a split capture, proving the filter threshold.
